oob_link_init: RTL and testbench

OOB_LINK_INIT -- requirements
Module: oob_link_init

---
 rtl/oob_link_init.sv | 184 ++++++++++++++++++
 tb/tb_oob_link_init.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oob_link_init.sv
// oob_link_init: SATA OOB link initialisation (COMRESET/COMWAKE, speed fallback, ALIGN insertion)
module oob_link_init #(
    parameter int BURST_CYC_G1  = 81,
    parameter int BURST_CYC_G2  = 162,
    parameter int TIMEOUT_CYC   = 132013,
    parameter int WAKE_HOLD_CYC = 63,
    parameter int MAX_RETRY     = 3,
    parameter int ALIGN_PERIOD  = 256,
    parameter int LOSS_CYC      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_locked,
    input  logic        gen2_cap,
    input  logic        restart,
    input  logic        cominitdet,
    input  logic        comwakedet,
    input  logic        rxelecidle,
    input  logic        rxbyteisaligned,
    input  logic [31:0] rx_datain,
    input  logic [3:0]  rx_charisk_in,
    input  logic [31:0] tx_datain,
    input  logic        tx_charisk_in,
    output logic        txcominit,
    output logic        txcomwake,
    output logic        txelecidle_out,
    output logic        rxreset,
    output logic [31:0] tx_dataout,
    output logic        tx_charisk_out,
    output logic [31:0] rx_dataout,
    output logic [3:0]  rx_charisk_out,
    output logic        linkup,
    output logic        align_en_out,
    output logic        gen_sel,
    output logic        link_fail,
    output logic [1:0]  retry_cnt,
    output logic [3:0]  state_out
);
    typedef enum logic [3:0] {
        COMRESET    = 4'd0,
        WAIT_CINIT  = 4'd1,
        COMWAKE     = 4'd2,
        WAIT_CWAKE  = 4'd3,
        WAKE_HOLD   = 4'd4,
        WAIT_NOIDLE = 4'd5,
        D10_2       = 4'd6,
        SEND_ALIGN  = 4'd7,
        READY       = 4'd8,
        FAIL        = 4'd9
    } state_t;

    localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
    localparam logic [31:0] D102_W  = 32'h4A4A4A4A;
    localparam logic [31:0] SYNC_W  = 32'hB5B5957C;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, loss_q, loss_d;
    logic [15:0] al_q, al_d;
    logic [1:0]  retry_q, retry_d;
    logic        gen_q, gen_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        tx_k_q, tx_k_d;
    logic        locked_q, cinit_q, cwake_q, idle_q, aligned_q;
    logic [31:0] rx_data_q;
    logic [3:0]  rx_k_q;
    logic        hold, timeout;
    logic [31:0] burst_m1;

    // GTX-side inputs are sampled once; every decision uses these copies
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_q  <= 1'b0;
            cinit_q   <= 1'b0;
            cwake_q   <= 1'b0;
            idle_q    <= 1'b0;
            aligned_q <= 1'b0;
            rx_data_q <= '0;
            rx_k_q    <= '0;
        end else begin
            locked_q  <= rx_locked;
            cinit_q   <= cominitdet;
            cwake_q   <= comwakedet;
            idle_q    <= rxelecidle;
            aligned_q <= rxbyteisaligned;
            rx_data_q <= rx_datain;
            rx_k_q    <= rx_charisk_in;
        end
    end

    // state, counters, retry/speed bookkeeping and registered TX word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= COMRESET;
            cnt_q     <= '0;
            loss_q    <= '0;
            al_q      <= '0;
            retry_q   <= '0;
            gen_q     <= gen2_cap;
            tx_data_q <= ALIGN_W;
            tx_k_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            al_q      <= al_d;
            retry_q   <= retry_d;
            gen_q     <= gen_d;
            tx_data_q <= tx_data_d;
            tx_k_q    <= tx_k_d;
        end
    end

    // next-state logic; a timeout retries COMRESET, falling back to Gen1 then FAIL
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        gen_d    = gen_q;
        hold     = 1'b0;
        timeout  = 1'b0;
        burst_m1 = gen_q ? 32'(BURST_CYC_G2 - 1) : 32'(BURST_CYC_G1 - 1);
        case (state_q)
            COMRESET:    if (!locked_q) hold = 1'b1;
                         else if (cnt_q == burst_m1) state_d = WAIT_CINIT;
            WAIT_CINIT:  if (cinit_q) state_d = COMWAKE;
                         else timeout = (cnt_q == 32'(TIMEOUT_CYC - 1));
            COMWAKE:     if (cnt_q == burst_m1) state_d = WAIT_CWAKE;
            WAIT_CWAKE:  if (cwake_q) state_d = WAKE_HOLD;
                         else timeout = (cnt_q == 32'(TIMEOUT_CYC - 1));
            WAKE_HOLD:   if (cnt_q == 32'(WAKE_HOLD_CYC - 1)) state_d = WAIT_NOIDLE;
            WAIT_NOIDLE: if (!idle_q) state_d = D10_2;
            D10_2:       if (rx_data_q == ALIGN_W && aligned_q) state_d = SEND_ALIGN;
                         else timeout = (cnt_q == 32'(TIMEOUT_CYC - 1));
            SEND_ALIGN:  if (rx_data_q == SYNC_W) begin
                             state_d = READY;
                             retry_d = '0;
                         end
            READY:       if (idle_q && loss_q == 32'(LOSS_CYC - 1)) begin
                             state_d = COMRESET;
                             retry_d = '0;
                             gen_d   = gen2_cap;
                         end
            FAIL:        if (restart) begin
                             state_d = COMRESET;
                             retry_d = '0;
                             gen_d   = gen2_cap;
                         end
            default:     state_d = COMRESET;
        endcase
        if (timeout) begin
            state_d = COMRESET;
            retry_d = retry_q + 2'd1;
            if ({30'd0, retry_q} + 32'd1 == 32'(MAX_RETRY)) begin
                if (gen_q) begin
                    gen_d   = 1'b0;
                    retry_d = '0;
                end else begin
                    state_d = FAIL;
                end
            end
        end
        cnt_d     = (state_d != state_q || hold) ? '0 : cnt_q + 32'd1;
        loss_d    = (state_q == READY && idle_q) ? loss_q + 32'd1 : '0;
        al_d      = (al_q == 16'(ALIGN_PERIOD - 1)) ? '0 : al_q + 16'd1;
        tx_data_d = (state_q == D10_2) ? D102_W :
                    (state_q == READY && !align_en_out) ? tx_datain : ALIGN_W;
        tx_k_d    = (state_q == SEND_ALIGN) ||
                    (state_q == READY && (align_en_out || tx_charisk_in));
    end

    assign align_en_out   = (al_q < 16'd2);
    assign txcominit      = (state_q == COMRESET) && locked_q;
    assign txcomwake      = (state_q == COMWAKE);
    assign txelecidle_out = !(state_q == D10_2 || state_q == SEND_ALIGN || state_q == READY);
    assign rxreset        = (state_q == WAIT_NOIDLE) && !idle_q;
    assign linkup         = (state_q == READY);
    assign link_fail      = (state_q == FAIL);
    assign gen_sel        = gen_q;
    assign retry_cnt      = retry_q;
    assign state_out      = state_q;
    assign tx_dataout     = tx_data_q;
    assign tx_charisk_out = tx_k_q;
    assign rx_dataout     = (state_q == READY || state_q == D10_2 || state_q == SEND_ALIGN) ? rx_data_q : '0;
    assign rx_charisk_out = (state_q == READY) ? rx_k_q : '0;
endmodule

// File: tb/tb_oob_link_init.sv
// tb_oob_link_init: directed scenario bench for oob_link_init
module tb_oob_link_init;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_locked = 1'b0, gen2_cap = 1'b1, restart = 1'b0;
    logic        cominitdet = 1'b0, comwakedet = 1'b0, rxelecidle = 1'b0, rxbyteisaligned = 1'b0;
    logic [31:0] rx_datain = '0, tx_datain = '0;
    logic [3:0]  rx_charisk_in = '0;
    logic        tx_charisk_in = 1'b0;
    logic        txcominit, txcomwake, txelecidle_out, rxreset, tx_charisk_out;
    logic [31:0] tx_dataout, rx_dataout;
    logic [3:0]  rx_charisk_out, state_out;
    logic        linkup, align_en_out, gen_sel, link_fail;
    logic [1:0]  retry_cnt;
    int total = 0;
    int bad = 0;

    oob_link_init #(.TIMEOUT_CYC(200)) dut (
        .clk(clk), .reset(reset), .rx_locked(rx_locked), .gen2_cap(gen2_cap), .restart(restart),
        .cominitdet(cominitdet), .comwakedet(comwakedet), .rxelecidle(rxelecidle),
        .rxbyteisaligned(rxbyteisaligned), .rx_datain(rx_datain), .rx_charisk_in(rx_charisk_in),
        .tx_datain(tx_datain), .tx_charisk_in(tx_charisk_in), .txcominit(txcominit),
        .txcomwake(txcomwake), .txelecidle_out(txelecidle_out), .rxreset(rxreset),
        .tx_dataout(tx_dataout), .tx_charisk_out(tx_charisk_out), .rx_dataout(rx_dataout),
        .rx_charisk_out(rx_charisk_out), .linkup(linkup), .align_en_out(align_en_out),
        .gen_sel(gen_sel), .link_fail(link_fail), .retry_cnt(retry_cnt), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
        int n = 0;
        while (state_out !== s && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (state_out !== s) begin
            bad++;
            $display("FAIL %s: state_out=%0d required %0d within %0d cycles", nm, state_out, s, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if (state_out !== 4'd0 || gen_sel !== 1'b1 || retry_cnt !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: state=%0d gen_sel=%b retry=%0d required 0 1 0", state_out, gen_sel, retry_cnt);
        end
        total++;
        if (txelecidle_out !== 1'b1 || linkup !== 1'b0 || link_fail !== 1'b0 || txcominit !== 1'b0 ||
            txcomwake !== 1'b0 || rxreset !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: idle=%b linkup=%b fail=%b cinit=%b cwake=%b rxrst=%b required 1 0 0 0 0 0",
                     txelecidle_out, linkup, link_fail, txcominit, txcomwake, rxreset);
        end
        total++;
        if (tx_dataout !== 32'h7B4A4ABC || tx_charisk_out !== 1'b0 || rx_dataout !== 32'h0 || rx_charisk_out !== 4'h0) begin
            bad++;
            $display("FAIL reset_data: tx=%h k=%b rx=%h rk=%h required 7b4a4abc 0 0 0",
                     tx_dataout, tx_charisk_out, rx_dataout, rx_charisk_out);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_gen2_fallback();
        int n = 0;
        int len = 0;
        rx_locked = 1'b1;
        while (txcominit !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        while (txcominit === 1'b1 && len < 1000) begin
            tick();
            len++;
        end
        total++;
        if (len != 162) begin
            bad++;
            $display("FAIL g2_burst_len: got %0d cycles required 162", len);
        end
        wait_state(4'd1, 10, "g2_wait_cinit");
        wait_state(4'd0, 300, "g2_first_timeout");
        total++;
        if (retry_cnt !== 2'd1 || gen_sel !== 1'b1) begin
            bad++;
            $display("FAIL g2_retry1: retry=%0d gen_sel=%b required 1 1", retry_cnt, gen_sel);
        end
        n = 0;
        while (gen_sel !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        total++;
        if (gen_sel !== 1'b0 || retry_cnt !== 2'd0 || state_out !== 4'd0) begin
            bad++;
            $display("FAIL g2_fallback: gen_sel=%b retry=%0d state=%0d required 0 0 0", gen_sel, retry_cnt, state_out);
        end
        len = 0;
        while (txcominit === 1'b1 && len < 1000) begin
            tick();
            len++;
        end
        total++;
        if (len != 81) begin
            bad++;
            $display("FAIL g1_burst_len: got %0d cycles required 81", len);
        end
    endtask

    task automatic test_fail_restart();
        wait_state(4'd9, 2000, "g1_to_fail");
        repeat (4) tick();
        total++;
        if (state_out !== 4'd9 || link_fail !== 1'b1 || txelecidle_out !== 1'b1 || txcominit !== 1'b0 || txcomwake !== 1'b0) begin
            bad++;
            $display("FAIL fail_hold: state=%0d fail=%b idle=%b cinit=%b cwake=%b required 9 1 1 0 0",
                     state_out, link_fail, txelecidle_out, txcominit, txcomwake);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        total++;
        if (state_out !== 4'd0 || link_fail !== 1'b0 || gen_sel !== 1'b1 || retry_cnt !== 2'd0) begin
            bad++;
            $display("FAIL restart: state=%0d fail=%b gen_sel=%b retry=%0d required 0 0 1 0",
                     state_out, link_fail, gen_sel, retry_cnt);
        end
    endtask

    task automatic test_handshake();
        int pulses = 0;
        wait_state(4'd1, 300, "hs_wait_cinit_a");
        wait_state(4'd0, 300, "hs_timeout");
        total++;
        if (retry_cnt !== 2'd1) begin
            bad++;
            $display("FAIL hs_retry_before: retry=%0d required 1", retry_cnt);
        end
        wait_state(4'd1, 300, "hs_wait_cinit_b");
        cominitdet = 1'b1;
        tick();
        cominitdet = 1'b0;
        wait_state(4'd2, 5, "hs_comwake");
        total++;
        if (txcomwake !== 1'b1 || txcominit !== 1'b0) begin
            bad++;
            $display("FAIL hs_comwake_out: cwake=%b cinit=%b required 1 0", txcomwake, txcominit);
        end
        rxelecidle = 1'b1;
        wait_state(4'd3, 300, "hs_wait_cwake");
        comwakedet = 1'b1;
        tick();
        comwakedet = 1'b0;
        wait_state(4'd4, 5, "hs_wake_hold");
        wait_state(4'd5, 100, "hs_wait_noidle");
        rxelecidle = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rxreset === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1 || state_out !== 4'd6) begin
            bad++;
            $display("FAIL hs_rxreset: pulses=%0d state=%0d required 1 6", pulses, state_out);
        end
        total++;
        if (tx_dataout !== 32'h4A4A4A4A || tx_charisk_out !== 1'b0 || txelecidle_out !== 1'b0) begin
            bad++;
            $display("FAIL hs_d10_2: tx=%h k=%b idle=%b required 4a4a4a4a 0 0", tx_dataout, tx_charisk_out, txelecidle_out);
        end
    endtask

    task automatic test_align_unaligned();
        rx_datain = 32'h7B4A4ABC;
        rx_charisk_in = 4'b0001;
        rxbyteisaligned = 1'b0;
        repeat (5) tick();
        total++;
        if (state_out !== 4'd6 || rx_dataout !== 32'h7B4A4ABC || rx_charisk_out !== 4'h0) begin
            bad++;
            $display("FAIL unaligned_stay: state=%0d rx=%h rk=%h required 6 7b4a4abc 0", state_out, rx_dataout, rx_charisk_out);
        end
        rxbyteisaligned = 1'b1;
        wait_state(4'd7, 5, "send_align");
        tick();
        total++;
        if (tx_dataout !== 32'h7B4A4ABC || tx_charisk_out !== 1'b1) begin
            bad++;
            $display("FAIL send_align_tx: tx=%h k=%b required 7b4a4abc 1", tx_dataout, tx_charisk_out);
        end
        tx_datain = 32'h12345678;
        tx_charisk_in = 1'b0;
        rx_datain = 32'hB5B5957C;
        wait_state(4'd8, 5, "ready");
        total++;
        if (linkup !== 1'b1 || retry_cnt !== 2'd0 || gen_sel !== 1'b1) begin
            bad++;
            $display("FAIL ready_flags: linkup=%b retry=%0d gen_sel=%b required 1 0 1", linkup, retry_cnt, gen_sel);
        end
        total++;
        if (rx_dataout !== 32'hB5B5957C || rx_charisk_out !== 4'b0001) begin
            bad++;
            $display("FAIL ready_rx: rx=%h rk=%h required b5b5957c 1", rx_dataout, rx_charisk_out);
        end
    endtask

    task automatic test_align_insertion();
        int ens = 0;
        int aligns = 0;
        int errs = 0;
        logic prev_en;
        prev_en = align_en_out;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (align_en_out === 1'b1) ens++;
            if (tx_dataout === 32'h7B4A4ABC && tx_charisk_out === 1'b1) aligns++;
            if (prev_en ? (tx_dataout !== 32'h7B4A4ABC || tx_charisk_out !== 1'b1)
                        : (tx_dataout !== 32'h12345678 || tx_charisk_out !== 1'b0)) errs++;
            prev_en = align_en_out;
        end
        total++;
        if (ens != 2 || aligns != 2 || errs != 0) begin
            bad++;
            $display("FAIL align_insert: en=%0d aligns=%0d errs=%0d required 2 2 0", ens, aligns, errs);
        end
    endtask

    task automatic test_link_loss();
        rxelecidle = 1'b1;
        repeat (15) tick();
        rxelecidle = 1'b0;
        repeat (3) tick();
        total++;
        if (linkup !== 1'b1 || state_out !== 4'd8) begin
            bad++;
            $display("FAIL idle15: linkup=%b state=%0d required 1 8", linkup, state_out);
        end
        gen2_cap = 1'b0;
        rxelecidle = 1'b1;
        repeat (16) tick();
        rxelecidle = 1'b0;
        repeat (2) tick();
        total++;
        if (linkup !== 1'b0 || state_out !== 4'd0 || gen_sel !== 1'b0 || retry_cnt !== 2'd0) begin
            bad++;
            $display("FAIL idle16: linkup=%b state=%0d gen_sel=%b retry=%0d required 0 0 0 0",
                     linkup, state_out, gen_sel, retry_cnt);
        end
    endtask

    task automatic test_reset_mid();
        gen2_cap = 1'b1;
        wait_state(4'd1, 200, "mid_wait_cinit");
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (state_out !== 4'd0 || gen_sel !== 1'b1 || txcominit !== 1'b0 || tx_dataout !== 32'h7B4A4ABC) begin
            bad++;
            $display("FAIL reset_mid: state=%0d gen_sel=%b cinit=%b tx=%h required 0 1 0 7b4a4abc",
                     state_out, gen_sel, txcominit, tx_dataout);
        end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_gen2_fallback();
        test_fail_restart();
        test_handshake();
        test_align_unaligned();
        test_align_insertion();
        test_link_loss();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
